redundancy_scanner: RTL and testbench

- Parametrised successor to the fixed-offset redundancy checker.
- Scans one lowered-IFM tile row by row at a runtime-selected column offset. Compares each source element with its distance-shifted neighbour in the next row and walks redundancy chains backwards.
- Reads the tile through a 1-cycle-latency table read port. Emits one table-update beat per row over a valid/ready handshake toward the table writer and free-list controller.
- Adds runtime offset, variable row count, chain-walk boundary checks, backpressure, abort and a redundancy counter.

---
 rtl/redundancy_pkg.sv | 30 +++
 rtl/chain_walker.sv | 55 +++++
 rtl/redundancy_scanner.sv | 232 +++++++++++++++++++++++
 tb/tb_redundancy_scanner.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redundancy_pkg.sv
// Shared definitions for the redundancy scanner.
//   ST_PLAIN/ST_RED/ST_HEAD : 2-bit table state codes
//   scan_state_t            : scanner FSM states
//   pack_addr()             : builds a {row,col} table address
package redundancy_pkg;

    localparam logic [1:0] ST_PLAIN = 2'b00;  // plain element
    localparam logic [1:0] ST_RED   = 2'b01;  // covered by an earlier row
    localparam logic [1:0] ST_HEAD  = 2'b10;  // head of a redundancy chain

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SRC,
        S_RD_DEST,
        S_CMP,
        S_CH_RD,
        S_CH_ACC,
        S_EMIT,
        S_NEXT,
        S_DONE
    } scan_state_t;

    // Callers truncate the result to their own address width.
    function automatic logic [31:0] pack_addr(input logic [31:0] row,
                                              input logic [31:0] col,
                                              input int          col_w);
        return (row << col_w) | col;
    endfunction

endpackage

// File: rtl/chain_walker.sv
// Pointer for walking a redundancy chain backwards, one row per step.
//   load/load_row/load_col : seed the pointer (cr,cc)
//   advance                : move the pointer to (nxt_row,nxt_col)
//   dist_vec/dist_except   : per-row column distance and no-neighbour flags
//   nxt_row/nxt_col        : candidate previous element (cr-1, cc+dist[cr-1])
//   blocked                : candidate column overflows or row pair has no link
//   at_row0                : pointer currently sits on row 0
module chain_walker
    import redundancy_pkg::*;
#(
    parameter int MAX_RSIZ   = 4,
    parameter int STEP_RANGE = 128,
    parameter int COL_WIDTH  = $clog2(STEP_RANGE),
    parameter int ROW_WIDTH  = $clog2(MAX_RSIZ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [ROW_WIDTH-1:0]          load_row,
    input  logic [COL_WIDTH-1:0]          load_col,
    input  logic                          advance,
    input  logic [MAX_RSIZ*COL_WIDTH-1:0] dist_vec,
    input  logic [MAX_RSIZ-1:0]           dist_except,
    output logic [ROW_WIDTH-1:0]          nxt_row,
    output logic [COL_WIDTH-1:0]          nxt_col,
    output logic                          blocked,
    output logic                          at_row0
);

    logic [ROW_WIDTH-1:0] cr;
    logic [COL_WIDTH-1:0] cc;
    logic [COL_WIDTH:0]   sum;

    // When cr is 0 the row index wraps; the result is never used because the
    // scanner stops walking once row 0 is reached.
    assign nxt_row = cr - 1'b1;
    assign sum     = {1'b0, cc} + {1'b0, dist_vec[nxt_row*COL_WIDTH +: COL_WIDTH]};
    assign nxt_col = sum[COL_WIDTH-1:0];
    assign blocked = sum[COL_WIDTH] | dist_except[nxt_row];
    assign at_row0 = (cr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cr <= '0;
            cc <= '0;
        end else if (load) begin
            cr <= load_row;
            cc <= load_col;
        end else if (advance) begin
            cr <= nxt_row;
            cc <= nxt_col;
        end
    end

endmodule

// File: rtl/redundancy_scanner.sv
// Scans a lowered-IFM tile row by row at a runtime column offset, compares
// each source element with its distance-shifted neighbour in the next row,
// walks redundancy chains backwards and emits one table-update beat per row.
//   start/abort/offset/rsiz         : scan control (offset/rsiz latched at start)
//   dist_except/dist_vec            : per-row neighbour distance info
//   rd_en/rd_addr/rd_word/rd_st/rd_mt : 1-cycle-latency table read port
//   wr_*/fl_valid/nr_valid          : update beat, valid/ready handshake
//   busy/done/red_cnt               : status
module redundancy_scanner
    import redundancy_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_RSIZ   = 4,
    parameter int STEP_RANGE = 128,
    parameter int COL_WIDTH  = $clog2(STEP_RANGE),
    parameter int ROW_WIDTH  = $clog2(MAX_RSIZ),
    parameter int RSIZ_WIDTH = $clog2(MAX_RSIZ+1),
    parameter int ITER_WIDTH = ROW_WIDTH + COL_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [COL_WIDTH-1:0]          offset,
    input  logic [RSIZ_WIDTH-1:0]         rsiz,
    input  logic [MAX_RSIZ-1:0]           dist_except,
    input  logic [MAX_RSIZ*COL_WIDTH-1:0] dist_vec,
    output logic                          rd_en,
    output logic [ITER_WIDTH-1:0]         rd_addr,
    input  logic [WORD_WIDTH-1:0]         rd_word,
    input  logic [1:0]                    rd_st,
    input  logic [STEP_RANGE-1:0]         rd_mt,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ITER_WIDTH-1:0]         wr_src_it,
    output logic [ITER_WIDTH-1:0]         wr_dest_it,
    output logic [STEP_RANGE-1:0]         wr_src_mt,
    output logic [1:0]                    wr_src_st,
    output logic [1:0]                    wr_dest_st,
    output logic                          fl_valid,
    output logic                          nr_valid,
    output logic                          busy,
    output logic                          done,
    output logic [RSIZ_WIDTH-1:0]         red_cnt
);

    scan_state_t           state;
    logic [ROW_WIDTH-1:0]  row;
    logic [COL_WIDTH-1:0]  off_q;
    logic [RSIZ_WIDTH-1:0] rsiz_q;
    logic                  dv_q;
    logic [WORD_WIDTH-1:0] src_word;
    logic [1:0]            src_st;

    logic [COL_WIDTH-1:0]  row_dist;
    logic [COL_WIDTH-1:0]  dest_col;
    logic [RSIZ_WIDTH-1:0] row_p1;
    logic                  dv_c;
    logic                  redc;

    logic [ROW_WIDTH-1:0]  w_nxt_row;
    logic [COL_WIDTH-1:0]  w_nxt_col;
    logic                  w_blocked;
    logic                  w_at_row0;

    function automatic logic [ITER_WIDTH-1:0] it_of(input logic [ROW_WIDTH-1:0] r,
                                                    input logic [COL_WIDTH-1:0] c);
        return ITER_WIDTH'(pack_addr(32'(r), 32'(c), COL_WIDTH));
    endfunction

    assign row_dist = dist_vec[row*COL_WIDTH +: COL_WIDTH];
    assign dest_col = off_q - row_dist;
    assign row_p1   = RSIZ_WIDTH'(row) + 1'b1;
    // Inputs of dv are stable across the row, so it is evaluated one state
    // early to let rd_en for the destination read come out of a register.
    assign dv_c     = !dist_except[row] && (row_dist <= off_q) && (row_p1 < rsiz_q);
    assign redc     = dv_q && (src_word == rd_word);

    // Seeded with (row,offset) during RD_SRC, so it is ready by CMP.
    chain_walker #(
        .MAX_RSIZ  (MAX_RSIZ),
        .STEP_RANGE(STEP_RANGE),
        .COL_WIDTH (COL_WIDTH),
        .ROW_WIDTH (ROW_WIDTH)
    ) u_walker (
        .clk        (clk),
        .reset      (reset),
        .load       (state == S_RD_SRC),
        .load_row   (row),
        .load_col   (off_q),
        .advance    ((state == S_CH_RD) && !w_blocked),
        .dist_vec   (dist_vec),
        .dist_except(dist_except),
        .nxt_row    (w_nxt_row),
        .nxt_col    (w_nxt_col),
        .blocked    (w_blocked),
        .at_row0    (w_at_row0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            row        <= '0;
            off_q      <= '0;
            rsiz_q     <= '0;
            dv_q       <= 1'b0;
            src_word   <= '0;
            src_st     <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            wr_valid   <= 1'b0;
            wr_src_it  <= '0;
            wr_dest_it <= '0;
            wr_src_mt  <= '0;
            wr_src_st  <= '0;
            wr_dest_st <= '0;
            fl_valid   <= 1'b0;
            nr_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            red_cnt    <= '0;
        end else if (abort) begin
            state    <= S_IDLE;
            rd_en    <= 1'b0;
            wr_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        off_q   <= offset;
                        rsiz_q  <= rsiz;
                        row     <= '0;
                        red_cnt <= '0;
                        if (rsiz == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_RD_SRC;
                            done    <= 1'b0;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= it_of('0, offset);
                        end
                    end
                end
                S_RD_SRC: begin
                    dv_q    <= dv_c;
                    rd_en   <= dv_c;
                    rd_addr <= it_of(row + 1'b1, dest_col);
                    state   <= S_RD_DEST;
                end
                S_RD_DEST: begin
                    src_word <= rd_word;
                    src_st   <= rd_st;
                    rd_en    <= 1'b0;
                    state    <= S_CMP;
                end
                S_CMP: begin
                    wr_src_it <= it_of(row, off_q);
                    if (redc) begin
                        wr_src_st  <= (src_st == ST_RED) ? ST_RED : ST_HEAD;
                        wr_dest_st <= ST_RED;
                        wr_dest_it <= it_of(row + 1'b1, dest_col);
                        wr_src_mt  <= (STEP_RANGE'(1) << off_q) | (STEP_RANGE'(1) << dest_col);
                        fl_valid   <= 1'b1;
                        nr_valid   <= 1'b0;
                        red_cnt    <= red_cnt + 1'b1;
                    end else begin
                        wr_src_st  <= src_st;
                        wr_dest_st <= dv_q ? rd_st : ST_PLAIN;
                        wr_dest_it <= '0;
                        wr_src_mt  <= STEP_RANGE'(1) << off_q;
                        fl_valid   <= 1'b0;
                        nr_valid   <= (src_st != ST_RED);
                    end
                    // An already-covered source extends an older chain: fold
                    // the mapping entries of its predecessors into this beat.
                    if (redc && src_st == ST_RED && row != '0) begin
                        state   <= S_CH_RD;
                        rd_en   <= !w_blocked;
                        rd_addr <= it_of(w_nxt_row, w_nxt_col);
                    end else begin
                        state    <= S_EMIT;
                        wr_valid <= 1'b1;
                    end
                end
                S_CH_RD: begin
                    rd_en <= 1'b0;
                    if (w_blocked) begin
                        state    <= S_EMIT;
                        wr_valid <= 1'b1;
                    end else begin
                        state <= S_CH_ACC;
                    end
                end
                S_CH_ACC: begin
                    wr_src_mt <= wr_src_mt | rd_mt;
                    if (rd_st == ST_HEAD || w_at_row0) begin
                        state    <= S_EMIT;
                        wr_valid <= 1'b1;
                    end else begin
                        state   <= S_CH_RD;
                        rd_en   <= !w_blocked;
                        rd_addr <= it_of(w_nxt_row, w_nxt_col);
                    end
                end
                S_EMIT: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (row_p1 == rsiz_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        row     <= row + 1'b1;
                        state   <= S_RD_SRC;
                        rd_en   <= 1'b1;
                        rd_addr <= it_of(row + 1'b1, off_q);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redundancy_scanner.sv
// Directed bench for redundancy_scanner: table model with 1-cycle read
// latency, beat monitor, hand-computed expected beats per scan.
module tb_redundancy_scanner;

    localparam int MR = 4;
    localparam int SR = 128;
    localparam int CW = 7;
    localparam int IW = 9;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [6:0]   offset;
    logic [2:0]   rsiz;
    logic [3:0]   dist_except;
    logic [27:0]  dist_vec;
    logic         rd_en;
    logic [8:0]   rd_addr;
    logic [7:0]   rd_word;
    logic [1:0]   rd_st;
    logic [127:0] rd_mt;
    logic         wr_valid, wr_ready;
    logic [8:0]   wr_src_it, wr_dest_it;
    logic [127:0] wr_src_mt;
    logic [1:0]   wr_src_st, wr_dest_st;
    logic         fl_valid, nr_valid, busy, done;
    logic [2:0]   red_cnt;

    redundancy_scanner dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .offset(offset), .rsiz(rsiz), .dist_except(dist_except), .dist_vec(dist_vec),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word), .rd_st(rd_st), .rd_mt(rd_mt),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_src_it(wr_src_it),
        .wr_dest_it(wr_dest_it), .wr_src_mt(wr_src_mt), .wr_src_st(wr_src_st),
        .wr_dest_st(wr_dest_st), .fl_valid(fl_valid), .nr_valid(nr_valid),
        .busy(busy), .done(done), .red_cnt(red_cnt)
    );

    always #5 clk = ~clk;

    // Table model
    logic [7:0]   t_word [MR][SR];
    logic [1:0]   t_st   [MR][SR];
    logic [127:0] t_mt   [MR][SR];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_word <= t_word[rd_addr[IW-1:CW]][rd_addr[CW-1:0]];
            rd_st   <= t_st[rd_addr[IW-1:CW]][rd_addr[CW-1:0]];
            rd_mt   <= t_mt[rd_addr[IW-1:CW]][rd_addr[CW-1:0]];
        end
    end

    // Beat / read monitor
    int           beat_cnt, rd_cnt;
    logic [8:0]   b_src [8];
    logic [8:0]   b_dst [8];
    logic [127:0] b_mt  [8];
    logic [1:0]   b_sst [8];
    logic [1:0]   b_dst_st [8];
    logic         b_fl [8];
    logic         b_nr [8];

    always @(negedge clk) begin
        if (rd_en) rd_cnt++;
        if (wr_valid && wr_ready) begin
            if (beat_cnt < 8) begin
                b_src[beat_cnt[2:0]]    = wr_src_it;
                b_dst[beat_cnt[2:0]]    = wr_dest_it;
                b_mt[beat_cnt[2:0]]     = wr_src_mt;
                b_sst[beat_cnt[2:0]]    = wr_src_st;
                b_dst_st[beat_cnt[2:0]] = wr_dest_st;
                b_fl[beat_cnt[2:0]]     = fl_valid;
                b_nr[beat_cnt[2:0]]     = nr_valid;
            end
            beat_cnt++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input int i, input logic [8:0] src, input logic [8:0] dst,
                            input logic [127:0] mt, input logic [1:0] sst,
                            input logic [1:0] dst_st, input logic fl, input logic nr);
        chk($sformatf("b%0d_src_it", i), 128'(b_src[i[2:0]]), 128'(src));
        chk($sformatf("b%0d_dest_it", i), 128'(b_dst[i[2:0]]), 128'(dst));
        chk($sformatf("b%0d_mt", i), b_mt[i[2:0]], mt);
        chk($sformatf("b%0d_src_st", i), 128'(b_sst[i[2:0]]), 128'(sst));
        chk($sformatf("b%0d_fl", i), 128'(b_fl[i[2:0]]), 128'(fl));
        chk($sformatf("b%0d_nr", i), 128'(b_nr[i[2:0]]), 128'(nr));
        if (fl) chk($sformatf("b%0d_dest_st", i), 128'(b_dst_st[i[2:0]]), 128'(dst_st));
    endtask

    function automatic logic [27:0] dv4(input logic [6:0] a, input logic [6:0] b,
                                        input logic [6:0] c, input logic [6:0] d);
        return {d, c, b, a};
    endfunction

    task automatic init_tab();
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < SR; c++) begin
                t_word[r[1:0]][c[6:0]] = 8'(r * 64 + c);
                t_st[r[1:0]][c[6:0]]   = 2'b00;
                t_mt[r[1:0]][c[6:0]]   = '0;
            end
    endtask

    task automatic setup_t1();
        init_tab();
        t_word[0][5] = 8'h33;
        t_word[1][4] = 8'h33;
        dist_vec    = dv4(7'd1, 7'd2, 7'd0, 7'd0);
        dist_except = 4'b0000;
    endtask

    task automatic setup_t2();
        init_tab();
        t_word[0][8] = 8'hA5;
        t_word[1][6] = 8'hA5;
        t_word[2][5] = 8'hA5;
        t_word[3][4] = 8'hA5;
        t_st[2][5]   = 2'b01;
        t_mt[1][6]   = (128'(1) << 40) | (128'(1) << 41);
        t_mt[0][8]   = (128'(1) << 100) | (128'(1) << 101);
        dist_vec    = dv4(7'd2, 7'd1, 7'd1, 7'd0);
        dist_except = 4'b0000;
    endtask

    task automatic clr();
        beat_cnt = 0;
        rd_cnt   = 0;
    endtask

    // Assumes the caller sits just after a rising edge.
    task automatic launch(input logic [2:0] rs, input logic [6:0] off);
        rsiz   = rs;
        offset = off;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", 128'(done), 128'(1'b1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, stable;
        logic [8:0]   s_src, s_dst;
        logic [127:0] s_mt;
        logic [1:0]   s_sst;
        logic         s_nr;

        reset = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
        offset = '0; rsiz = '0; dist_except = '0; dist_vec = '0;
        beat_cnt = 0; rd_cnt = 0;
        init_tab();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid", 128'(wr_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_red_cnt", 128'(red_cnt), 128'(3'd0));
        chk("rst_rd_en", 128'(rd_en), 128'(1'b0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic scan: row0 covers row1 col4
        setup_t1(); clr();
        launch(3'd3, 7'd5);
        chk("t1_busy", 128'(busy), 128'(1'b1));
        wait_done(100, n);
        chk("t1_cycles", 128'(n), 128'(15));
        chk("t1_beats", 128'(beat_cnt), 128'(3));
        chk("t1_reads", 128'(rd_cnt), 128'(5));
        chk("t1_red_cnt", 128'(red_cnt), 128'(3'd1));
        chk("t1_busy_end", 128'(busy), 128'(1'b0));
        chk_beat(0, 9'd5, 9'd132, 128'h30, 2'b10, 2'b01, 1'b1, 1'b0);
        chk_beat(1, 9'd133, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);
        chk_beat(2, 9'd261, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);

        // Chain walk: row2 already covered, walks back through rows 1 and 0
        setup_t2(); clr();
        launch(3'd4, 7'd5);
        wait_done(100, n);
        chk("t2_cycles", 128'(n), 128'(24));
        chk("t2_beats", 128'(beat_cnt), 128'(4));
        chk("t2_reads", 128'(rd_cnt), 128'(9));
        chk("t2_red_cnt", 128'(red_cnt), 128'(3'd1));
        chk_beat(0, 9'd5, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);
        chk_beat(1, 9'd133, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);
        chk_beat(2, 9'd261, 9'd388,
                 (128'(1) << 5) | (128'(1) << 4) | (128'(1) << 40) | (128'(1) << 41) |
                 (128'(1) << 100) | (128'(1) << 101),
                 2'b01, 2'b01, 1'b1, 1'b0);
        chk_beat(3, 9'd389, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);

        // No-neighbour rows: distance beyond offset, and dist_except
        init_tab();
        t_word[1][127] = t_word[0][5];
        t_word[2][4]   = t_word[1][5];
        t_st[1][5]     = 2'b01;
        dist_vec    = dv4(7'd6, 7'd1, 7'd0, 7'd0);
        dist_except = 4'b0010;
        clr();
        launch(3'd3, 7'd5);
        wait_done(100, n);
        chk("t3_cycles", 128'(n), 128'(15));
        chk("t3_reads", 128'(rd_cnt), 128'(3));
        chk("t3_red_cnt", 128'(red_cnt), 128'(3'd0));
        chk("t3_beats", 128'(beat_cnt), 128'(3));
        chk_beat(0, 9'd5, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);
        chk_beat(1, 9'd133, 9'd0, 128'(1) << 5, 2'b01, 2'b00, 1'b0, 1'b0);
        chk_beat(2, 9'd261, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);

        // Backpressure on beat1
        setup_t1(); clr();
        launch(3'd3, 7'd5);
        k = 0;
        while (beat_cnt < 1 && k < 50) begin @(posedge clk); #1; k++; end
        wr_ready = 1'b0;
        k = 0;
        while (!wr_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("t4_valid_seen", 128'(wr_valid), 128'(1'b1));
        s_src = wr_src_it; s_dst = wr_dest_it; s_mt = wr_src_mt;
        s_sst = wr_src_st; s_nr = nr_valid;
        stable = 0;
        repeat (7) begin
            @(posedge clk); #1;
            if (wr_valid && wr_src_it == s_src && wr_dest_it == s_dst &&
                wr_src_mt == s_mt && wr_src_st == s_sst && nr_valid == s_nr)
                stable++;
        end
        chk("t4_stable", 128'(stable), 128'(7));
        chk("t4_no_accept", 128'(beat_cnt), 128'(1));
        wr_ready = 1'b1;
        wait_done(100, n);
        chk("t4_beats", 128'(beat_cnt), 128'(3));
        chk_beat(1, 9'd133, 9'd0, 128'(1) << 5, 2'b00, 2'b00, 1'b0, 1'b1);

        // Chain column overflow stops the walk without accumulating
        init_tab();
        t_word[1][126] = 8'hEE;
        t_word[2][125] = 8'hEE;
        t_st[1][126]   = 2'b01;
        t_mt[0][1]     = 128'(1) << 7;
        dist_vec    = dv4(7'd3, 7'd1, 7'd0, 7'd0);
        dist_except = 4'b0000;
        clr();
        launch(3'd3, 7'd126);
        wait_done(100, n);
        chk("t5_cycles", 128'(n), 128'(16));
        chk("t5_reads", 128'(rd_cnt), 128'(5));
        chk("t5_beats", 128'(beat_cnt), 128'(3));
        chk("t5_red_cnt", 128'(red_cnt), 128'(3'd1));
        chk_beat(0, 9'd126, 9'd0, 128'(1) << 126, 2'b00, 2'b00, 1'b0, 1'b1);
        chk_beat(1, 9'd254, 9'd381, (128'(1) << 126) | (128'(1) << 125),
                 2'b01, 2'b01, 1'b1, 1'b0);

        // Abort from DONE, then an empty scan
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_done_clr", 128'(done), 128'(1'b0));
        clr();
        launch(3'd0, 7'd3);
        wait_done(5, n);
        chk("rs0_cycles", 128'(n), 128'(0));
        repeat (3) begin @(posedge clk); #1; end
        chk("rs0_beats", 128'(beat_cnt), 128'(0));
        chk("rs0_reads", 128'(rd_cnt), 128'(0));
        chk("rs0_busy", 128'(busy), 128'(1'b0));

        // Abort in the middle of the chain walk
        setup_t2(); clr();
        launch(3'd4, 7'd5);
        k = 0;
        while (rd_cnt < 7 && k < 100) begin @(posedge clk); #1; k++; end
        chk("t6_reached_walk", 128'(rd_cnt), 128'(7));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t6_busy", 128'(busy), 128'(1'b0));
        chk("t6_done", 128'(done), 128'(1'b0));
        chk("t6_wr_valid", 128'(wr_valid), 128'(1'b0));
        chk("t6_rd_en", 128'(rd_en), 128'(1'b0));
        repeat (10) begin @(posedge clk); #1; end
        chk("t6_beats", 128'(beat_cnt), 128'(2));
        chk("t6_reads", 128'(rd_cnt), 128'(7));

        // Reset while holding a beat in EMIT
        setup_t1(); clr();
        wr_ready = 1'b0;
        launch(3'd3, 7'd5);
        k = 0;
        while (!wr_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("t7_emit", 128'(wr_valid), 128'(1'b1));
        chk("t7_red_pre", 128'(red_cnt), 128'(3'd1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t7_wr_valid", 128'(wr_valid), 128'(1'b0));
        chk("t7_done", 128'(done), 128'(1'b0));
        chk("t7_red_cnt", 128'(red_cnt), 128'(3'd0));
        chk("t7_busy", 128'(busy), 128'(1'b0));
        wr_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("t7_beats", 128'(beat_cnt), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
